// File: rtl/pakin_rx.sv
// pakio link receiver: reassembles FSZ-bit flits into a PSZ-bit packet, checks
// address range and redundancy, and forwards good packets on a 4-phase channel.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 14
`endif

// state     | meaning
// RESYNC    | wait for both handshakes idle after reset
// RX_IDLE   | waiting for the next flit request
// RX_ACK    | flit acknowledged, waiting for request release
// CHECK     | one cycle: validate packet, deliver or drop
// TX_WAIT   | packet offered, waiting for consumer ack
// TX_DONE   | waiting for consumer ack release
module pakin_rx #(
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int RSZ      = `NS_REDUN_SIZE,
  parameter int PSZ      = `NS_PACKET_SIZE,
  parameter int FSZ      = 2,
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 14,
  parameter int CSZ      = 8
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic           i0_req,
  input  logic [FSZ-1:0] i0_data,
  output logic           i0_ack,
  output logic           snd0_req,
  output logic [PSZ-1:0] snd0_data,
  input  logic           snd0_ack,
  output logic [CSZ-1:0] pak_cnt,
  output logic [CSZ-1:0] err_cnt
);

  localparam int NUM_FLITS = PSZ / FSZ;
  localparam int FCW       = $clog2(NUM_FLITS + 1);
  localparam logic [ASZ-1:0] MIN_A    = ASZ'(MIN_ADDR);
  localparam logic [ASZ-1:0] MAX_A    = ASZ'(MAX_ADDR);
  localparam logic [FCW-1:0] LAST_CNT = FCW'(NUM_FLITS);

  if ((PSZ != ASZ + DSZ + RSZ) || ((PSZ % FSZ) != 0)) begin : g_bad_params
    $error("pakin_rx: inconsistent packet/flit sizes");
  end

  typedef enum logic [2:0] {
    S_RESYNC  = 3'd0,
    S_RX_IDLE = 3'd1,
    S_RX_ACK  = 3'd2,
    S_CHECK   = 3'd3,
    S_TX_WAIT = 3'd4,
    S_TX_DONE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_req_m, r_req_s;
  logic r_ack_m, r_ack_s;

  logic           r_ready;
  logic           r_i0_ack;
  logic           r_snd_req;
  logic [PSZ-1:0] r_snd_data;
  logic [PSZ-1:0] r_shift;
  logic [FCW-1:0] r_flit_cnt;
  logic [CSZ-1:0] r_pak_cnt;
  logic [CSZ-1:0] r_err_cnt;

  logic           w_take_flit;
  logic           w_flit_rel;
  logic           w_deliver;
  logic           w_drop;
  logic           w_tx_ack;
  logic           w_last_flit;
  logic           w_good;
  logic [ASZ-1:0] w_addr;
  logic [DSZ-1:0] w_data;
  logic [RSZ-1:0] w_red;
  logic [RSZ-1:0] w_red_calc;

  // Synchronisers reset high so RESYNC cannot exit before real input levels arrive.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_req_m <= 1'b1;
      r_req_s <= 1'b1;
      r_ack_m <= 1'b1;
      r_ack_s <= 1'b1;
    end else begin
      r_req_m <= i0_req;
      r_req_s <= r_req_m;
      r_ack_m <= snd0_ack;
      r_ack_s <= r_ack_m;
    end
  end

  assign w_addr      = r_shift[PSZ-1 -: ASZ];
  assign w_data      = r_shift[RSZ +: DSZ];
  assign w_red       = r_shift[RSZ-1:0];
  assign w_red_calc  = RSZ'(w_addr) + RSZ'(w_data);
  assign w_good      = (w_addr >= MIN_A) && (w_addr <= MAX_A) && (w_red == w_red_calc);
  assign w_last_flit = (r_flit_cnt == LAST_CNT);

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RESYNC;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESYNC:  if (!r_req_s && !r_ack_s) w_next = S_RX_IDLE;
      S_RX_IDLE: if (r_req_s) w_next = S_RX_ACK;
      S_RX_ACK:  if (!r_req_s) w_next = w_last_flit ? S_CHECK : S_RX_IDLE;
      S_CHECK:   w_next = w_good ? S_TX_WAIT : S_RX_IDLE;
      S_TX_WAIT: if (r_ack_s) w_next = S_TX_DONE;
      S_TX_DONE: if (!r_ack_s) w_next = S_RX_IDLE;
      default:   w_next = S_RESYNC;
    endcase
  end

  always_comb begin
    w_take_flit = 1'b0;
    w_flit_rel  = 1'b0;
    w_deliver   = 1'b0;
    w_drop      = 1'b0;
    w_tx_ack    = 1'b0;
    case (r_state)
      S_RX_IDLE: w_take_flit = r_req_s;
      S_RX_ACK:  w_flit_rel  = !r_req_s;
      S_CHECK: begin
        w_deliver = w_good;
        w_drop    = !w_good;
      end
      S_TX_WAIT: w_tx_ack = r_ack_s;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_i0_ack   <= 1'b0;
      r_snd_req  <= 1'b0;
      r_snd_data <= '0;
      r_shift    <= '0;
      r_flit_cnt <= '0;
      r_pak_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_take_flit) begin
        r_shift    <= {r_shift[PSZ-FSZ-1:0], i0_data};
        r_flit_cnt <= r_flit_cnt + FCW'(1);
        r_i0_ack   <= 1'b1;
      end
      if (w_flit_rel) begin
        r_i0_ack <= 1'b0;
        if (w_last_flit) r_flit_cnt <= '0;
      end
      if (w_deliver) begin
        r_snd_data <= r_shift;
        r_snd_req  <= 1'b1;
      end
      if (w_drop && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CSZ'(1);
      end
      if (w_tx_ack) begin
        r_snd_req <= 1'b0;
        r_pak_cnt <= r_pak_cnt + CSZ'(1);
      end
    end
  end

  assign ready     = r_ready;
  assign i0_ack    = r_i0_ack;
  assign snd0_req  = r_snd_req;
  assign snd0_data = r_snd_data;
  assign pak_cnt   = r_pak_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pakin_rx.sv
// Self-checking bench for pakin_rx: table-driven packets, scoreboard on the
// send channel, plus back-pressure, mid-packet reset and counter-limit sequences.

module tb_pakin_rx;

  localparam int PSZ = 14;
  localparam int FSZ = 2;
  localparam int NF  = 7;
  localparam int CSZ = 8;

  logic           i_clk;
  logic           reset;
  logic           ready;
  logic           i0_req;
  logic [FSZ-1:0] i0_data;
  logic           i0_ack;
  logic           snd0_req;
  logic [PSZ-1:0] snd0_data;
  logic           snd0_ack;
  logic [CSZ-1:0] pak_cnt;
  logic [CSZ-1:0] err_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_pak = 0;
  int exp_err = 0;
  logic [PSZ-1:0] sb[$];
  bit hold_ack = 1'b0;

  typedef struct {
    logic [PSZ-1:0] pkt;
    bit             good;
  } vec_t;
  vec_t vecs[9];

  pakin_rx dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .ready    (ready),
    .i0_req   (i0_req),
    .i0_data  (i0_data),
    .i0_ack   (i0_ack),
    .snd0_req (snd0_req),
    .snd0_data(snd0_data),
    .snd0_ack (snd0_ack),
    .pak_cnt  (pak_cnt),
    .err_cnt  (err_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [PSZ-1:0] mk_pkt(input int a, input int d);
    return {a[5:0], d[3:0], 4'(a + d)};
  endfunction

  function automatic bit is_good(input logic [PSZ-1:0] p);
    int a = int'(p[13:8]);
    int d = int'(p[7:4]);
    return (a >= 1) && (a <= 14) && (p[3:0] == 4'(a + d));
  endfunction

  task automatic wait_ack(input logic val);
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (i0_ack == val) return;
    end
    chk("i0_ack_timeout", 32'(i0_ack), 32'(val));
  endtask

  task automatic send_flit(input logic [FSZ-1:0] f);
    i0_data = f;
    i0_req  = 1'b1;
    wait_ack(1'b1);
    i0_req = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic send_range(input logic [PSZ-1:0] p, input int first, input int last_excl);
    for (int k = first; k < last_excl; k++) send_flit(p[PSZ-1-FSZ*k -: FSZ]);
  endtask

  // Push expectation and update the counter model as the packet is driven.
  task automatic model_pkt(input logic [PSZ-1:0] p);
    if (is_good(p)) begin
      sb.push_back(p);
      exp_pak = (exp_pak + 1) % 256;
    end else if (exp_err < 255) begin
      exp_err++;
    end
  endtask

  task automatic send_pkt(input logic [PSZ-1:0] p);
    model_pkt(p);
    send_range(p, 0, NF);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      if (sb.size() == 0 && !snd0_req && !snd0_ack) begin
        repeat (6) @(negedge i_clk);
        return;
      end
    end
    chk("idle_timeout", 32'(sb.size()), 0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pak"}, 32'(pak_cnt), 32'(exp_pak));
    chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    exp_pak = 0;
    exp_err = 0;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_i0_ack", 32'(i0_ack), 0);
    chk("rst_snd0_req", 32'(snd0_req), 0);
    chk("rst_snd0_data", 32'(snd0_data), 0);
    chk("rst_pak_cnt", 32'(pak_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    reset = 1'b0;
    @(negedge i_clk);
    chk("ready_after_rst", 32'(ready), 1);
  endtask

  // Consumer: compare each offered packet once, then ack unless held off.
  initial begin
    bit seen = 1'b0;
    snd0_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!snd0_req) begin
        seen = 1'b0;
        snd0_ack = 1'b0;
      end else begin
        if (!seen) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_pkt: got 0x%0h with empty queue", snd0_data);
          end else begin
            chk("pkt_data", 32'(snd0_data), 32'(sb.pop_front()));
          end
          seen = 1'b1;
        end
        if (!hold_ack) snd0_ack = 1'b1;
      end
    end
  end

  // Handshake invariants, sampled after the DUT edge.
  initial begin
    logic p_ack  = 1'b0;
    logic p_sreq = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!reset) begin
        if (i0_ack && !p_ack) chk("ack_rise_req", 32'(i0_req), 1);
        if (!i0_ack && p_ack) chk("ack_fall_req", 32'(i0_req), 0);
        if (snd0_req && !p_sreq) chk("sreq_rise_ack", 32'(snd0_ack), 0);
      end
      p_ack  = i0_ack;
      p_sreq = snd0_req;
    end
  end

  initial begin
    repeat (95000) @(posedge i_clk);
    n_total++;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    logic [PSZ-1:0] pa, pb;
    bit saw;

    vecs[0] = '{14'h05AF, 1'b1};
    vecs[1] = '{14'h05AE, 1'b0};
    vecs[2] = '{14'h05AF, 1'b1};
    vecs[3] = '{{6'd1, 4'h3, 4'h4}, 1'b1};
    vecs[4] = '{{6'd14, 4'h5, 4'h3}, 1'b1};
    vecs[5] = '{{6'd0, 4'h2, 4'h2}, 1'b0};
    vecs[6] = '{{6'd15, 4'h1, 4'h0}, 1'b0};
    vecs[7] = '{{6'd63, 4'hF, 4'hE}, 1'b0};
    vecs[8] = '{{6'd7, 4'h9, 4'h0}, 1'b1};

    i0_req  = 1'b0;
    i0_data = '0;
    reset   = 1'b1;
    do_reset();
    repeat (4) @(negedge i_clk);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].good) begin
        sb.push_back(vecs[i].pkt);
        exp_pak = (exp_pak + 1) % 256;
      end else begin
        exp_err++;
      end
      send_range(vecs[i].pkt, 0, NF);
      wait_idle();
      chk_counts($sformatf("vec%0d", i));
    end

    // Back-pressure: next flit offered while the packet is held unacked.
    hold_ack = 1'b1;
    pa = mk_pkt(3, 12);
    pb = mk_pkt(10, 6);
    send_pkt(pa);
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (snd0_req) begin
        saw = 1'b1;
        break;
      end
    end
    chk("bp_req_up", 32'(saw), 1);
    model_pkt(pb);
    i0_data = pb[PSZ-1 -: FSZ];
    i0_req  = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (i0_ack) saw = 1'b1;
    end
    chk("bp_ack_held", 32'(saw), 0);
    chk("bp_req_held", 32'(snd0_req), 1);
    chk("bp_data_held", 32'(snd0_data), 32'(pa));
    hold_ack = 1'b0;
    wait_ack(1'b1);
    i0_req = 1'b0;
    wait_ack(1'b0);
    send_range(pb, 1, NF);
    wait_idle();
    chk_counts("bp");

    // Reset after 3 flits with the 4th request still high through release.
    pa = mk_pkt(14, 5);
    send_range(pa, 0, 3);
    i0_data = pa[PSZ-1-FSZ*3 -: FSZ];
    i0_req  = 1'b1;
    repeat (4) @(negedge i_clk);
    do_reset();
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      if (i0_ack) saw = 1'b1;
    end
    chk("resync_no_ack", 32'(saw), 0);
    i0_req = 1'b0;
    repeat (5) @(negedge i_clk);
    send_pkt(mk_pkt(9, 6));
    wait_idle();
    chk_counts("post_rst");

    // Counter limits.
    do_reset();
    for (int i = 0; i < 255; i++) send_pkt(mk_pkt(0, i % 16));
    wait_idle();
    chk("err_255", 32'(err_cnt), 32'(exp_err));
    send_pkt(mk_pkt(5, 1) ^ 14'd1);
    wait_idle();
    chk("err_sat", 32'(err_cnt), 32'(exp_err));
    chk("err_sat_pak", 32'(pak_cnt), 32'(exp_pak));
    for (int i = 0; i < 255; i++) begin
      send_pkt(mk_pkt(int'($urandom_range(1, 14)), int'($urandom_range(0, 15))));
    end
    wait_idle();
    chk("pak_255", 32'(pak_cnt), 32'(exp_pak));
    send_pkt(mk_pkt(1, 0));
    wait_idle();
    chk("pak_wrap", 32'(pak_cnt), 32'(exp_pak));
    chk("pak_wrap_err", 32'(err_cnt), 32'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
